// File: rtl/dmem_pkg.sv
// Shared types and widths for the pipelined backing data memory.
package dmem_pkg;

  // Default configuration and the widths derived from it.
  localparam int unsigned MEM_DEPTH_DEF       = 16384;
  localparam int unsigned BLOCK_SIZE_DEF      = 16;
  localparam int unsigned DELAY_DEF           = 50;
  localparam int unsigned MAX_OUTSTANDING_DEF = 4;
  localparam int unsigned TAG_W_DEF           = 4;

  localparam int unsigned AW  = $clog2(MEM_DEPTH_DEF);
  localparam int unsigned NW  = BLOCK_SIZE_DEF / 4;
  localparam int unsigned TSW = $clog2(DELAY_DEF + 1) + 1;

  // Field widths of a queued request. They are sized for the largest
  // supported configuration; an instance only drives the low bits it
  // needs and the upper bits stay at zero.
  localparam int unsigned ENTRY_ADDR_W = 32;
  localparam int unsigned ENTRY_DATA_W = 512;
  localparam int unsigned ENTRY_NW     = ENTRY_DATA_W / 32;
  localparam int unsigned ENTRY_TAG_W  = 16;
  localparam int unsigned ENTRY_TS_W   = 16;

  typedef struct packed {
    logic                    is_write;
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_DATA_W-1:0] din;
    logic [ENTRY_NW-1:0]     wmask;
    logic [ENTRY_TAG_W-1:0]  tag;
    logic [ENTRY_TS_W-1:0]   ts;
  } req_entry_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Timestamp width needed so that an age of DELAY is distinguishable
  // from a wrapped counter.
  function automatic int unsigned ts_width(input int unsigned delay);
    return $clog2(delay + 1) + 1;
  endfunction

endpackage

// File: rtl/dmem_req_fifo.sv
// In-order request queue holding accepted memory requests until retirement.
module dmem_req_fifo
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_OUTSTANDING_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  req_entry_t din,
  output req_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  req_entry_t       slots [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so a single-entry queue also works.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = slots[rd_ptr];

  // Pointer and occupancy bookkeeping; reset drops every queued request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are meaningless while the slot is free.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= din;
  end

endmodule

// File: rtl/pipelined_data_memory.sv
// Block-wide backing memory with fixed DELAY latency, in-order retirement,
// per-word write masking, request tags and an optional post-reset clear.
module pipelined_data_memory
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH       = MEM_DEPTH_DEF,
  parameter int unsigned BLOCK_SIZE      = BLOCK_SIZE_DEF,
  parameter int unsigned DELAY           = DELAY_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int unsigned TAG_W           = TAG_W_DEF,
  parameter int unsigned CLEAR_ON_RESET  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
  input  logic [BLOCK_SIZE/4-1:0] wmask,
  input  logic [TAG_W-1:0]        req_tag,
  output logic                    mem_ready,
  output logic                    is_output_valid,
  output logic [BLOCK_SIZE*8-1:0] dout,
  output logic                    write_ack,
  output logic [TAG_W-1:0]        resp_tag
);

  localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);
  localparam int unsigned WORDS  = BLOCK_SIZE / 4;
  localparam int unsigned BLK_W  = BLOCK_SIZE * 8;
  localparam int unsigned TS_W   = ts_width(DELAY);

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   clear_idx;
  logic [ADDR_W-1:0]   clear_idx_next;
  logic                clear_we;
  logic [TS_W-1:0]     now;
  logic [BLK_W-1:0]    mem [MEM_DEPTH];

  req_entry_t          push_entry;
  req_entry_t          head;
  logic                full;
  logic                empty;
  logic                accept;
  logic                retire;
  logic [ADDR_W-1:0]   head_addr;
  logic [BLK_W-1:0]    head_din;
  logic [WORDS-1:0]    head_mask;
  logic [TAG_W-1:0]    head_tag;
  logic [TS_W-1:0]     head_ts;
  logic [TS_W-1:0]     head_age;
  logic                unused_bits;

  // New requests are refused during reset, during the clear sweep and
  // whenever the queue is full; a same-cycle retire does not help.
  assign mem_ready = reset & ~full & (state == RUN);
  assign accept    = is_input_valid & (mem_read | mem_write) & mem_ready;

  // Pack the incoming request; a read+write request is stored as a write.
  always_comb begin
    push_entry                  = '0;
    push_entry.is_write         = mem_write;
    push_entry.addr[ADDR_W-1:0] = addr[ADDR_W-1:0];
    push_entry.din[BLK_W-1:0]   = din;
    push_entry.wmask[WORDS-1:0] = wmask;
    push_entry.tag[TAG_W-1:0]   = req_tag;
    push_entry.ts[TS_W-1:0]     = now;
  end

  dmem_req_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (retire),
    .din   (push_entry),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign head_addr   = head.addr[ADDR_W-1:0];
  assign head_din    = head.din[BLK_W-1:0];
  assign head_mask   = head.wmask[WORDS-1:0];
  assign head_tag    = head.tag[TAG_W-1:0];
  assign head_ts     = head.ts[TS_W-1:0];
  assign head_age    = now - head_ts;
  assign retire      = ~empty & (head_age == TS_W'(DELAY));
  assign unused_bits = ^{addr, head};

  // Free-running timestamp; wrapping is harmless thanks to the modular age.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) now <= '0;
    else        now <= now + 1'b1;
  end

  // Clear/run state register; reset restarts any sweep at index 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clear_idx <= '0;
    end else begin
      state     <= state_next;
      clear_idx <= clear_idx_next;
    end
  end

  // Sweep one block per cycle, then hand over to normal operation.
  always_comb begin
    state_next     = state;
    clear_idx_next = clear_idx;
    clear_we       = 1'b0;
    case (state)
      CLEAR: begin
        clear_we       = 1'b1;
        clear_idx_next = clear_idx + 1'b1;
        if (clear_idx == ADDR_W'(MEM_DEPTH - 1)) begin
          state_next     = RUN;
          clear_idx_next = '0;
        end
      end
      RUN:     state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Storage array: sweep writes or masked retiring writes; never reset.
  always_ff @(posedge clk) begin
    if (clear_we && reset) begin
      mem[clear_idx] <= '0;
    end else if (retire && head.is_write) begin
      for (int i = 0; i < int'(WORDS); i++) begin
        if (head_mask[i]) mem[head_addr][32*i +: 32] <= head_din[32*i +: 32];
      end
    end
  end

  // Response pulses for the retiring head; outputs idle at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_output_valid <= 1'b0;
      write_ack       <= 1'b0;
      dout            <= '0;
      resp_tag        <= '0;
    end else begin
      is_output_valid <= retire & ~head.is_write;
      write_ack       <= retire & head.is_write;
      resp_tag        <= retire ? head_tag : '0;
      dout            <= (retire && !head.is_write) ? mem[head_addr] : '0;
    end
  end

endmodule

// File: tb/tb_pipelined_data_memory.sv
// Scoreboard bench for pipelined_data_memory: directed requests, a reference
// memory image, and a monitor that checks every response and idle cycle.
module tb_pipelined_data_memory;

  localparam int DELAY   = 6;
  localparam int MAX_OUT = 4;
  localparam int DEPTH   = 16;

  logic         clk;
  logic         reset;
  logic         is_input_valid;
  logic [31:0]  addr;
  logic         mem_read;
  logic         mem_write;
  logic [127:0] din;
  logic [3:0]   wmask;
  logic [3:0]   req_tag;
  logic         mem_ready;
  logic         is_output_valid;
  logic [127:0] dout;
  logic         write_ack;
  logic [3:0]   resp_tag;

  typedef struct {
    logic         is_write;
    logic [3:0]   tag;
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t         sb [$];
  logic [127:0] model_mem [DEPTH];
  int           cyc;
  int           tests_run;
  int           tests_failed;

  pipelined_data_memory #(
    .MEM_DEPTH       (DEPTH),
    .BLOCK_SIZE      (16),
    .DELAY           (DELAY),
    .MAX_OUTSTANDING (MAX_OUT),
    .TAG_W           (4),
    .CLEAR_ON_RESET  (1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (is_input_valid),
    .addr            (addr),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .din             (din),
    .wmask           (wmask),
    .req_tag         (req_tag),
    .mem_ready       (mem_ready),
    .is_output_valid (is_output_valid),
    .dout            (dout),
    .write_ack       (write_ack),
    .resp_tag        (resp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after rising edge E it reads E.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  // Drive one request, hold it until accepted, then record the expectation.
  task automatic applyStimulus(input bit wr, input bit rd, input logic [31:0] a,
                               input logic [127:0] d, input logic [3:0] m,
                               input logic [3:0] t, output int acc_edge);
    bit   got;
    bit   rdy;
    int   c;
    int   n;
    exp_t e;
    is_input_valid = 1'b1;
    mem_write = wr;
    mem_read = rd;
    addr = a;
    din = d;
    wmask = m;
    req_tag = t;
    got = 1'b0;
    acc_edge = -1;
    n = 0;
    while (!got && n < 200) begin
      rdy = mem_ready;
      c = cyc;
      @(posedge clk);
      #1;
      if (rdy) begin
        got = 1'b1;
        acc_edge = c + 1;
      end
      n++;
    end
    is_input_valid = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    checkOutput("accepted", {127'd0, got}, 128'd1);
    if (got) begin
      e.is_write = wr;
      e.tag = t;
      e.due = acc_edge + DELAY;
      e.data = '0;
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (m[i]) model_mem[a[3:0]][32*i +: 32] = d[32*i +: 32];
      end else begin
        e.data = model_mem[a[3:0]];
      end
      sb.push_back(e);
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 128'(sb.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic measureClear();
    int  low;
    bit  done;
    low = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (mem_ready) done = 1'b1;
      else low++;
    end
    checkOutput("clear_cycles", 128'(low), 128'd16);
  endtask

  // Monitor: every response is matched against the scoreboard head;
  // otherwise the outputs must sit at zero.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      checkOutput("reset_ready", {127'd0, mem_ready}, 128'd0);
      checkOutput("reset_pulses", {126'd0, is_output_valid, write_ack}, 128'd0);
      checkOutput("reset_dout", dout, 128'd0);
      checkOutput("reset_tag", {124'd0, resp_tag}, 128'd0);
    end else if (is_output_valid || write_ack) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_pulse", {126'd0, is_output_valid, write_ack}, 128'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("resp_kind", {126'd0, is_output_valid, write_ack},
                    e.is_write ? 128'd1 : 128'd2);
        checkOutput("resp_tag", {124'd0, resp_tag}, {124'd0, e.tag});
        checkOutput("resp_cycle", 128'(cyc), 128'(e.due));
        checkOutput("resp_dout", dout, e.data);
      end
    end else begin
      checkOutput("idle_dout", dout, 128'd0);
      checkOutput("idle_tag", {124'd0, resp_tag}, 128'd0);
    end
  end

  initial begin
    int e0;
    int ea [6];
    logic [127:0] x;
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b0;
    is_input_valid = 1'b0;
    addr = '0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    din = '0;
    wmask = '0;
    req_tag = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    // Power-up reset followed by the clear sweep.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    measureClear();

    // Single write then read of a preloaded value.
    applyStimulus(1, 0, 32'd3, 128'hA5, 4'hF, 4'd1, e0);
    applyStimulus(0, 1, 32'd3, '0, 4'h0, 4'd2, e0);
    waitDrain();

    // Masked write followed immediately by a read of the same block.
    applyStimulus(1, 0, 32'd7, {128{1'b1}}, 4'b0101, 4'd1, e0);
    applyStimulus(0, 1, 32'd7, '0, 4'h0, 4'd3, e0);
    waitDrain();
    checkOutput("masked_model", model_mem[7], 128'h00000000_FFFFFFFF_00000000_FFFFFFFF);

    // All-zero mask still acks but leaves memory unchanged; upper addr bits ignored.
    applyStimulus(1, 0, 32'hFFFF_0007, {128{1'b1}}, 4'h0, 4'd4, e0);
    applyStimulus(0, 1, 32'h0001_0007, '0, 4'h0, 4'd5, e0);
    waitDrain();

    // Read and write together behave as a write only.
    applyStimulus(1, 1, 32'd5, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 4'hF, 4'd6, e0);
    applyStimulus(0, 1, 32'd5, '0, 4'h0, 4'd7, e0);
    waitDrain();

    // Valid without read or write is ignored.
    is_input_valid = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    is_input_valid = 1'b0;
    repeat (DELAY + 4) @(posedge clk);
    #1;

    // Read / write / read back-to-back to one block.
    x = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(0, 1, 32'd3, '0, 4'h0, 4'd8, e0);
    applyStimulus(1, 0, 32'd3, x, 4'hF, 4'd9, e0);
    applyStimulus(0, 1, 32'd3, '0, 4'h0, 4'd10, e0);
    waitDrain();

    // Backpressure: queue of four fills, fifth waits for the first retire.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        applyStimulus(1, 0, 32'(i + 8), {$urandom, $urandom, $urandom, $urandom}, 4'hF, 4'(i), ea[i]);
      else
        applyStimulus(0, 1, 32'(i + 7), '0, 4'h0, 4'(i), ea[i]);
    end
    checkOutput("full_rate_edge", 128'(ea[3]), 128'(ea[0] + 3));
    checkOutput("backpressure_edge", 128'(ea[4]), 128'(ea[0] + DELAY + 1));
    waitDrain();

    // Reset with three reads in flight: all dropped, then a fresh clear.
    applyStimulus(0, 1, 32'd3, '0, 4'h0, 4'd1, e0);
    applyStimulus(0, 1, 32'd5, '0, 4'h0, 4'd2, e0);
    applyStimulus(0, 1, 32'd7, '0, 4'h0, 4'd3, e0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    measureClear();

    // Every block reads back zero with normal latency.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(0, 1, 32'(i), '0, 4'h0, 4'(i), e0);
    waitDrain();
    repeat (DELAY + 2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
